// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : Pixel/line counters with registered sync, active-video and
//            line/frame pulses, all aligned to the same (x_px, y_px).
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       px_en,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       activevideo,
    output logic       hsync,
    output logic       vsync,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_h_last     = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_v_last     = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       active_q, active_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_end_q, line_end_d;
    logic       frame_end_q, frame_end_d;
    logic [7:0] frame_count_q, frame_count_d;

    logic       w_x_wrap;
    logic       w_y_wrap;

    assign w_x_wrap = (x_q == c_h_last);
    assign w_y_wrap = (y_q == c_v_last);

    // Decode flags from the next position so every registered output
    // describes the same coordinate as the registered counters.
    always_comb begin
        x_d           = w_x_wrap ? 10'd0 : x_q + 10'd1;
        y_d           = y_q;
        frame_count_d = frame_count_q;
        if (w_x_wrap) begin
            y_d = w_y_wrap ? 10'd0 : y_q + 10'd1;
            if (w_y_wrap) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
        active_d    = (x_d < c_h_vis) && (y_d < c_v_vis);
        hsync_d     = ((x_d >= c_hs_start) && (x_d < c_hs_end)) ? SYNC_POL : ~SYNC_POL;
        vsync_d     = ((y_d >= c_vs_start) && (y_d < c_vs_end)) ? SYNC_POL : ~SYNC_POL;
        line_end_d  = (x_d == c_h_last);
        frame_end_d = (x_d == c_h_last) && (y_d == c_v_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            active_q      <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_count_q <= 8'd0;
        end else if (px_en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign x_px        = x_q;
    assign y_px        = y_q;
    assign activevideo = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_end    = line_end_q;
    assign frame_end   = frame_end_q;
    assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Directed checks of vga_sync_gen on a default 640x480 instance
//            and a tiny 10x7 active-high instance for frame-level behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst, d_en;
    logic [9:0] d_x, d_y;
    logic       d_act, d_hs, d_vs, d_le, d_fe;
    logic [7:0] d_fc;

    logic       s_rst, s_en;
    logic [9:0] s_x, s_y;
    logic       s_act, s_hs, s_vs, s_le, s_fe;
    logic [7:0] s_fc;

    int n_checks = 0;
    int n_fail   = 0;

    vga_sync_gen dut (
        .clk(clk), .reset(d_rst), .px_en(d_en),
        .x_px(d_x), .y_px(d_y), .activevideo(d_act),
        .hsync(d_hs), .vsync(d_vs), .line_end(d_le),
        .frame_end(d_fe), .frame_count(d_fc)
    );

    // Small raster: H total 10 (visible 0..3, sync 6..8), V total 7 (visible 0..2, sync 4..5)
    vga_sync_gen #(
        .H_VISIBLE(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .reset(s_rst), .px_en(s_en),
        .x_px(s_x), .y_px(s_y), .activevideo(s_act),
        .hsync(s_hs), .vsync(s_vs), .line_end(s_le),
        .frame_end(s_fe), .frame_count(s_fc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int mx, my;
    int le_cnt, fe_cnt, act_cnt;
    logic e_act, e_hs, e_vs, e_le, e_fe;

    initial begin
        d_rst = 1'b1; s_rst = 1'b1;
        d_en  = 1'b0; s_en  = 1'b0;
        #2;
        check("reset_dflt", {d_x, d_y, d_act, d_hs, d_vs, d_le, d_fe, d_fc},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        check("reset_small", {s_x, s_y, s_act, s_hs, s_vs, s_le, s_fe, s_fc},
              {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        #1;
        d_rst = 1'b0; s_rst = 1'b0; d_en = 1'b1;
        step(1);
        check("first_edge", {d_x, d_y, d_act}, {10'd1, 10'd0, 1'b1});

        step(637);
        check("x638", {d_x, d_y, d_act}, {10'd638, 10'd0, 1'b1});
        step(1);
        check("x639_act", {d_x, d_act}, {10'd639, 1'b1});
        step(1);
        check("x640_inact", {d_x, d_act}, {10'd640, 1'b0});
        step(15);
        check("hs_655", {d_x, d_hs}, {10'd655, 1'b1});
        step(1);
        check("hs_656", {d_x, d_hs}, {10'd656, 1'b0});
        step(95);
        check("hs_751", {d_x, d_hs}, {10'd751, 1'b0});
        step(1);
        check("hs_752", {d_x, d_hs}, {10'd752, 1'b1});

        step(8047);
        check("line_end_799_10", {d_x, d_y, d_le, d_fe}, {10'd799, 10'd10, 1'b1, 1'b0});
        step(1);
        check("line_wrap", {d_x, d_y, d_le, d_vs}, {10'd0, 10'd11, 1'b0, 1'b1});

        // Hold with enable low on the default instance
        d_en = 1'b0;
        step(3);
        check("hold_dflt", {d_x, d_y}, {10'd0, 10'd11});
        d_en = 1'b1;
        step(5);
        check("resume_dflt", {d_x, d_y}, {10'd5, 10'd11});

        // Asynchronous reset mid-frame, sampled before the next edge
        #2 d_rst = 1'b1;
        #1;
        check("async_reset", {d_x, d_y, d_act, d_hs, d_vs, d_le, d_fe, d_fc},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
        step(1);
        check("reset_held", {d_x, d_y}, {10'd0, 10'd0});
        #2 d_rst = 1'b0;
        step(1);
        check("post_reset_edge", {d_x, d_y, d_act}, {10'd1, 10'd0, 1'b1});
        d_en = 1'b0;

        // Full frame on the small raster against a position model
        s_en = 1'b1;
        mx = 0; my = 0;
        le_cnt = 0; fe_cnt = 0; act_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            step(1);
            if (mx == 9) begin
                mx = 0;
                my = (my == 6) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            e_act = (mx < 4) && (my < 3);
            e_hs  = (mx >= 6) && (mx < 9);
            e_vs  = (my >= 4) && (my < 6);
            e_le  = (mx == 9);
            e_fe  = (mx == 9) && (my == 6);
            check("small_frame", {s_x, s_y, s_act, s_hs, s_vs, s_le, s_fe},
                  {mx[9:0], my[9:0], e_act, e_hs, e_vs, e_le, e_fe});
            le_cnt  += int'(s_le);
            fe_cnt  += int'(s_fe);
            act_cnt += int'(s_act);
        end
        check("frame_end_count", 64'(fe_cnt), 64'd1);
        check("line_end_count", 64'(le_cnt), 64'd7);
        check("active_count", 64'(act_cnt), 64'd12);
        check("frame_count_1", {s_x, s_y, s_fc}, {10'd0, 10'd0, 8'd1});

        step(254 * 70 + 69);
        check("last_px_fc255", {s_x, s_y, s_fe, s_le, s_vs, s_fc},
              {10'd9, 10'd6, 1'b1, 1'b1, 1'b0, 8'd255});

        s_en = 1'b0;
        step(5);
        check("hold_frame_end", {s_x, s_y, s_fe, s_le, s_fc},
              {10'd9, 10'd6, 1'b1, 1'b1, 8'd255});
        s_en = 1'b1;
        step(1);
        check("frame_wrap", {s_x, s_y, s_fe, s_act, s_fc},
              {10'd0, 10'd0, 1'b0, 1'b1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, active level of hsync/vsync (0 = active-low).
REQ-010 Port clk: input, 1 bit, single pixel clock; the block has one clock.
REQ-011 Port reset: input, 1 bit; reset is asynchronous and active-high.
REQ-012 Port px_en: input, 1 bit, pixel advance enable; counters hold when low.
REQ-013 Port x_px: output, 10 bits, current horizontal position (0..H_TOTAL-1).
REQ-014 Port y_px: output, 10 bits, current vertical position (0..V_TOTAL-1).
REQ-015 Port activevideo: output, 1 bit, high iff x_px < H_VISIBLE and y_px < V_VISIBLE.
REQ-016 Port hsync: output, 1 bit, horizontal sync at SYNC_POL level during the sync window.
REQ-017 Port vsync: output, 1 bit, vertical sync at SYNC_POL level during the sync window.
REQ-018 Port line_end: output, 1 bit, single-cycle pulse on the last pixel of each line.
REQ-019 Port frame_end: output, 1 bit, single-cycle pulse on the last pixel of each frame (drives button throttle enable).
REQ-020 Port frame_count: output, 8 bits, completed-frame counter.

Function
REQ-021 H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
REQ-022 All outputs shall be registered, with every output describing the same (x_px, y_px) in the same cycle (no skew between position and sync/active/pulses).
REQ-023 On a clk edge with px_en=1: x_px increments; when x_px = H_TOTAL-1 it wraps to 0 and y_px increments; when y_px = V_TOTAL-1 on that same edge it also wraps to 0.
REQ-024 On a clk edge with px_en=0, all outputs shall hold their values, including line_end/frame_end (a pulse persists while px_en is low).
REQ-025 hsync shall be at SYNC_POL iff H_VISIBLE+H_FRONT <= x_px < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default), else at ~SYNC_POL.
REQ-026 vsync shall be at SYNC_POL iff V_VISIBLE+V_FRONT <= y_px < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default), independent of x_px.
REQ-027 line_end shall be 1 iff x_px = H_TOTAL-1.
REQ-028 frame_end shall be 1 iff x_px = H_TOTAL-1 and y_px = V_TOTAL-1.
REQ-029 frame_count shall increment by 1 (mod 256, wrapping 255->0) on the edge where the position wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-030 Position arithmetic shall be unsigned 10-bit; counters shall never hold values >= H_TOTAL / V_TOTAL.

Reset
REQ-031 While reset=1, outputs shall immediately (without a clk edge) take: x_px=0, y_px=0, activevideo=1, hsync=~SYNC_POL, vsync=~SYNC_POL, line_end=0, frame_end=0, frame_count=0.
REQ-032 Reset asserted mid-frame shall abandon the frame; after release, the first clk edge with px_en=1 shall move to (1,0).

Verification
REQ-033 Assert reset async between edges -> outputs reach REQ-031 values before the next edge; release, 1 enabled edge -> x_px=1, y_px=0, activevideo=1.
REQ-034 Run from (638,0) -> x_px=639 activevideo=1, x_px=640 activevideo=0; hsync=1 at 655, 0 at 656..751, 1 at 752.
REQ-035 At (799,10) -> line_end=1, frame_end=0; next edge -> (0,11), line_end=0.
REQ-036 At (799,524), frame_count=255 -> frame_end=1; next edge -> (0,0), frame_end=0, frame_count=0, activevideo=1; vsync=0 only on y=490..491.
REQ-037 At (799,524) hold px_en=0 for 5 edges -> frame_end stays 1, position unchanged; raise px_en -> wrap occurs on the first enabled edge.
REQ-038 Full-frame run of 420000 enabled edges -> exactly one frame_end pulse, 525 line_end pulses, activevideo high for exactly 307200 cycles.
